// File: rtl/exec_trace_buffer.sv
// Execution-trace capture ring for the multicycle core: arm, trigger on PC,
// post-trigger fill, then serial readout. Optional stamps: TRACE_CYCLE_STAMP_EN.
module exec_trace_buffer #(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 16,
  parameter int POST_CNT     = 8,
  parameter int STOP_ON_FULL = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       arm,
  input  logic [XLEN-1:0]            trig_pc,
  input  logic [3:0]                 state_i,
  input  logic [XLEN-1:0]            pc_i,
  input  logic                       rf_we_i,
  input  logic [4:0]                 rf_addr_i,
  input  logic [XLEN-1:0]            rf_data_i,
  input  logic                       mem_we_i,
  input  logic [XLEN-1:0]            mem_addr_i,
  input  logic [XLEN-1:0]            mem_data_i,
  input  logic                       rd_req,
  output logic                       rd_valid,
  output logic [12+4*XLEN-1:0]       rd_data,
  output logic [31:0]                rd_stamp,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       busy,
  output logic                       triggered,
  output logic                       done,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 12 + 4 * XLEN;
  localparam int PEFF = (POST_CNT > DEPTH) ? DEPTH :
                        ((POST_CNT < 1) ? 1 : POST_CNT);

  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] C_PEFF = CW'(PEFF);
  localparam logic [AW-1:0] P_ONE  = AW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_POST,
    S_DONE
  } st_t;

  st_t           st;
  logic [3:0]    prev_state;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] pcnt;
  logic [EW-1:0] mem [DEPTH];

  logic [2:0]    mask;
  logic [EW-1:0] entry;
  logic          capturing;
  logic          full;
  logic          is_trig;
  logic          drop;
  logic          wr_en;
  logic          rd_fire;

  always_comb begin
    mask = {state_i != prev_state,
            rf_we_i && (rf_addr_i != 5'd0),
            mem_we_i};
    entry = {mask, state_i, rf_addr_i, pc_i,
             rf_data_i, mem_addr_i, mem_data_i};
    capturing = ((st == S_ARMED) || (st == S_POST)) && (mask != 3'b000);
    full = (count == C_FULL);
    is_trig = (st == S_ARMED) && (pc_i == trig_pc);
    // The trigger entry is always kept, even when a stopped buffer is full.
    drop = full && (STOP_ON_FULL != 0) && (st == S_ARMED) && !is_trig;
    wr_en = capturing && !drop && !arm;
    rd_fire = (st == S_DONE) && rd_req && (count != '0) && !arm;
  end

  assign busy = (st == S_ARMED) || (st == S_POST);
  assign done = (st == S_DONE);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr] <= entry;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st         <= S_IDLE;
      prev_state <= '0;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      pcnt       <= '0;
      triggered  <= 1'b0;
      overflow   <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
    end else begin
      prev_state <= state_i;
      if (arm) begin
        st        <= S_ARMED;
        wptr      <= '0;
        rptr      <= '0;
        count     <= '0;
        pcnt      <= '0;
        triggered <= 1'b0;
        overflow  <= 1'b0;
        rd_valid  <= 1'b0;
      end else begin
        rd_valid <= rd_fire;
        if (rd_fire) begin
          rd_data <= mem[rptr];
          rptr    <= rptr + P_ONE;
          count   <= count - C_ONE;
        end
        if (capturing && full) begin
          overflow <= 1'b1;
        end
        if (wr_en) begin
          wptr <= wptr + P_ONE;
          if (full) begin
            rptr <= rptr + P_ONE;
          end else begin
            count <= count + C_ONE;
          end
        end
        unique case (st)
          S_IDLE: begin
          end
          S_ARMED: begin
            if (capturing && is_trig) begin
              triggered <= 1'b1;
              pcnt      <= C_ONE;
              st        <= (PEFF == 1) ? S_DONE : S_POST;
            end
          end
          S_POST: begin
            if (capturing) begin
              pcnt <= pcnt + C_ONE;
              if (pcnt + C_ONE == C_PEFF) begin
                st <= S_DONE;
              end
            end
          end
          S_DONE: begin
          end
          default: st <= S_IDLE;
        endcase
      end
    end
  end

`ifdef TRACE_CYCLE_STAMP_EN
  logic [31:0] cyc;
  logic [31:0] stamp_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      stamp_mem[wptr] <= cyc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc      <= '0;
      rd_stamp <= '0;
    end else begin
      cyc <= arm ? 32'd0 : cyc + 32'd1;
      if (rd_fire) begin
        rd_stamp <= stamp_mem[rptr];
      end
    end
  end
`else
  assign rd_stamp = 32'd0;
`endif

endmodule
